// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: port FSM states, default widths
// and the address field that selects a slave or bridge.
package bus_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  // Top address bits pick the slave/bridge; the rest are the in-slave offset.
  localparam int SLAVE_SEL_BITS = 2;
  localparam int SLAVE_SEL_LSB  = ADDR_WIDTH_DEF - SLAVE_SEL_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WAIT_ACK,
    ST_WDATA,
    ST_RDATA,
    ST_SPLIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load, serial-in/serial-out shift register with a down-counter of
// remaining bits; bits leave from the MSB and enter at the LSB.
module serial_shifter #(
  parameter int W = 8,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          shift,
  input  logic          sin,
  output logic          sout,
  output logic [W-1:0]  q_next,
  output logic          last
);

  logic [W-1:0]  q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= CW'(W - 1);
    end else if (shift) begin
      q   <= q_next;
      cnt <= cnt - 1'b1;
    end
  end

  assign sout   = q[W-1];
  assign q_next = {q[W-2:0], sin};
  assign last   = (cnt == '0);

endmodule

// File: rtl/serial_master_port.sv
// Master-side bus port: requests the serial bus, shifts out the address, waits
// for the slave ack, then shifts write data out or read data in.
module serial_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  mode,
  output logic                  wr_bus,
  input  logic                  rd_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  output logic                  master_ready,
  input  logic                  slave_valid,
  input  logic                  ack,
  input  logic                  split,
  output state_e                state_dbg
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic                  write_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [TW-1:0]         tcnt_q;

  logic                  start_acc, a_shift, d_shift, t_inc, err_set, rd_capture;
  logic                  a_sout, a_last, d_sout, d_last;
  logic [ADDR_WIDTH-1:0] addr_next_unused;
  logic [DATA_WIDTH-1:0] d_next;

  assign start_acc = (state_q == ST_IDLE) && start;

  // Both shifters load at start; the data counter stays at its top value until
  // the data phase begins, so no reload is needed on ack.
  serial_shifter #(.W(ADDR_WIDTH)) u_addr_sh (
    .clk(clk), .rst(rst), .load(start_acc), .load_val(addr),
    .shift(a_shift), .sin(1'b0), .sout(a_sout), .q_next(addr_next_unused),
    .last(a_last)
  );

  serial_shifter #(.W(DATA_WIDTH)) u_data_sh (
    .clk(clk), .rst(rst), .load(start_acc), .load_val(wdata),
    .shift(d_shift), .sin(rd_bus), .sout(d_sout), .q_next(d_next),
    .last(d_last)
  );

  // Handshake: a bit moves on a rising edge where the sender's valid and the
  // receiver's ready are both high; valid never waits on ready, and a split in
  // a data state wins over a bit offered in the same cycle (it is re-sent).
  always_comb begin
    state_d    = state_q;
    a_shift    = 1'b0;
    d_shift    = 1'b0;
    t_inc      = 1'b0;
    err_set    = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_REQ;
      ST_REQ:      if (bgrant) state_d = ST_ADDR;
      ST_ADDR: begin
        if (bgrant && slave_ready) begin
          a_shift = 1'b1;
          if (a_last) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          state_d = write_q ? ST_WDATA : ST_RDATA;
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_WDATA: begin
        if (split) begin
          state_d = ST_SPLIT;
        end else if (bgrant && slave_ready) begin
          d_shift = 1'b1;
          if (d_last) state_d = ST_DONE;
        end
      end
      ST_RDATA: begin
        if (split) begin
          state_d = ST_SPLIT;
        end else if (bgrant && slave_valid) begin
          d_shift = 1'b1;
          if (d_last) begin
            rd_capture = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_SPLIT:    if (!split && bgrant) state_d = write_q ? ST_WDATA : ST_RDATA;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= t_inc ? tcnt_q + 1'b1 : '0;
      if (start_acc) begin
        write_q <= write;
        err_q   <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (rd_capture) rdata_q <= d_next;
    end
  end

  logic in_txn, granted_phase;
  assign in_txn        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign granted_phase = in_txn && (state_q != ST_REQ);

  assign busy         = in_txn;
  assign breq         = in_txn;
  assign done         = (state_q == ST_DONE);
  assign err          = done && err_q;
  assign mode         = granted_phase && write_q;
  assign master_valid = bgrant && ((state_q == ST_ADDR) || (state_q == ST_WDATA));
  assign master_ready = bgrant && (state_q == ST_RDATA);
  assign wr_bus       = master_valid && ((state_q == ST_ADDR) ? a_sout : d_sout);
  assign rdata        = rdata_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_serial_master_port.sv
// Directed bench for serial_master_port: a transaction-level model predicts
// every output each cycle, and literal checks pin the serial streams and results.
module tb_serial_master_port;
  import bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int ACK_TO = 16;

  localparam int P_IDLE = 0, P_REQ = 1, P_ADDR = 2, P_WACK = 3,
                 P_DATA = 4, P_SPLIT = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic rst, start, write, bgrant, rd_bus, slave_ready, slave_valid, ack, split;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic busy, done, err, breq, mode, wr_bus, master_valid, master_ready;
  state_e state_dbg;

  serial_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .breq(breq), .bgrant(bgrant), .mode(mode), .wr_bus(wr_bus),
    .rd_bus(rd_bus), .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid), .ack(ack),
    .split(split), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  int           m_ph = P_IDLE;
  bit           m_write, m_err;
  logic [DW-1:0] m_wdata, m_rx, m_rdata;
  int           m_wait, m_nleft;
  logic [0:0]   exp_q[$];   // serial bits still owed on wr_bus, MSB first

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_rdata = '0; m_err = 1'b0; m_write = 1'b0;
      exp_q.delete();
    end else begin
      case (m_ph)
        P_IDLE: if (start) begin
          m_ph = P_REQ; m_write = write; m_wdata = wdata; m_err = 1'b0;
          exp_q.delete();
          for (int i = AW - 1; i >= 0; i--) exp_q.push_back(addr[i]);
        end
        P_REQ: if (bgrant) m_ph = P_ADDR;
        P_ADDR: if (bgrant && slave_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin m_ph = P_WACK; m_wait = 0; end
        end
        P_WACK: begin
          if (ack) begin
            m_ph = P_DATA;
            if (m_write) for (int i = DW - 1; i >= 0; i--) exp_q.push_back(m_wdata[i]);
            else begin m_nleft = DW; m_rx = '0; end
          end else if (m_wait == ACK_TO - 1) begin
            m_ph = P_DONE; m_err = 1'b1;
          end else m_wait++;
        end
        P_DATA: begin
          if (split) m_ph = P_SPLIT;
          else if (bgrant && m_write && slave_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_ph = P_DONE;
          end else if (bgrant && !m_write && slave_valid) begin
            m_rx = m_rx * 2 + DW'(rd_bus);
            m_nleft--;
            if (m_nleft == 0) begin m_rdata = m_rx; m_ph = P_DONE; end
          end
        end
        P_SPLIT: if (!split && bgrant) m_ph = P_DATA;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // ---------------- compare process and stream capture ----------------
  logic [63:0] got;
  int got_n, wack_n;

  always @(negedge clk) begin
    bit e_busy, e_done, e_mv, e_mr, e_wr, e_mode;
    if (chk_en) begin
      e_busy = (m_ph >= P_REQ) && (m_ph <= P_SPLIT);
      e_done = (m_ph == P_DONE);
      e_mode = (m_ph >= P_ADDR) && (m_ph <= P_SPLIT) && m_write;
      e_mv   = bgrant && (m_ph == P_ADDR || (m_ph == P_DATA && m_write));
      e_mr   = bgrant && (m_ph == P_DATA) && !m_write;
      e_wr   = e_mv && (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("breq", 32'(breq), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_done && m_err));
      chk("mode", 32'(mode), 32'(e_mode));
      chk("master_valid", 32'(master_valid), 32'(e_mv));
      chk("master_ready", 32'(master_ready), 32'(e_mr));
      chk("wr_bus", 32'(wr_bus), 32'(e_wr));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (master_valid && slave_ready && !(split && m_ph == P_DATA) && !rst) begin
        got = {got[62:0], wr_bus};
        got_n++;
      end
      if (state_dbg == ST_WAIT_ACK) wack_n++;
    end
  end

  // ---------------- slave responder ----------------
  int ack_delay = 2;
  bit sv_toggle = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  always @(posedge clk) begin
    #1;
    ack = (m_ph == P_WACK) && (ack_delay >= 0) && (m_wait >= ack_delay);
    slave_valid = sv_toggle ? !slave_valid : 1'b1;
    rd_bus = (m_ph == P_DATA && !m_write && m_nleft > 0) ? s_rdata[m_nleft - 1] : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = w; addr = a; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_data(input int left, input bit by_bits, input string nm);
    int n = 0;
    while (!(m_ph == P_DATA && (by_bits ? (m_nleft == left) : (exp_q.size() == left))) && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) chk({nm, "_wait"}, 32'(m_ph), 32'(P_DATA));
  endtask

  task automatic finish_txn(input string nm, input bit e_err, input logic [DW-1:0] e_rdata);
    int n = 0;
    while (m_ph != P_DONE && n < 300) begin tick(); n++; end
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    chk({nm, "_rdata"}, 32'(rdata), 32'(e_rdata));
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; start = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    bgrant = 1'b1; rd_bus = 1'b0; slave_ready = 1'b1; slave_valid = 1'b1;
    ack = 1'b0; split = 1'b0; got = '0; got_n = 0; wack_n = 0;
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();

    // write 0x1234 <- 0xA5, ack two cycles late, extra start mid-flight ignored
    got_n = 0; ack_delay = 2;
    do_start(1'b1, 16'h1234, 8'hA5);
    tick(); tick(); tick();
    do_start(1'b0, 16'hFFFF, 8'h00);
    finish_txn("wr1", 1'b0, 8'h00);
    chk("wr1_bits_n", 32'(got_n), 32'd24);
    chk("wr1_bits", {8'h0, got[23:0]}, 32'h001234A5);

    // read 0x2000 -> 0x3C, slave_valid toggling, grant loss and split in ADDR
    got_n = 0; sv_toggle = 1'b1; s_rdata = 8'h3C;
    do_start(1'b0, 16'h2000, 8'h77);
    while (!(m_ph == P_ADDR && exp_q.size() == 10)) tick();
    bgrant = 1'b0; tick(); tick(); tick(); bgrant = 1'b1;
    split = 1'b1; tick(); tick(); split = 1'b0;
    finish_txn("rd1", 1'b0, 8'h3C);
    chk("rd1_addr_bits", {16'h0, got[15:0]}, 32'h00002000);
    sv_toggle = 1'b0;

    // no ack: timeout after exactly ACK_TO cycles, no data phase, rdata kept
    got_n = 0; wack_n = 0; ack_delay = -1;
    do_start(1'b1, 16'h3000, 8'h11);
    finish_txn("to", 1'b1, 8'h3C);
    chk("to_wait_cycles", 32'(wack_n), 32'(ACK_TO));
    chk("to_bits_n", 32'(got_n), 32'd16);
    ack_delay = 0;

    // write split after 3 data bits, grant dropped inside the split
    got_n = 0;
    do_start(1'b1, 16'h4001, 8'hA5);
    wait_data(5, 1'b0, "sp");
    split = 1'b1; tick(); tick(); tick();
    bgrant = 1'b0; tick(); tick(); tick(); tick();
    bgrant = 1'b1; tick(); tick(); tick();
    split = 1'b0;
    finish_txn("sp", 1'b0, 8'h3C);
    chk("sp_bits_n", 32'(got_n), 32'd24);
    chk("sp_bits", {8'h0, got[23:0]}, 32'h004001A5);

    // read split coinciding with a valid bit: that bit is received after resume
    s_rdata = 8'h96;
    do_start(1'b0, 16'h8100, 8'h00);
    wait_data(4, 1'b1, "rsp");
    split = 1'b1; tick(); tick(); tick(); split = 1'b0;
    finish_txn("rsp", 1'b0, 8'h96);

    // reset in the middle of write data, then a clean transaction
    do_start(1'b1, 16'h5555, 8'hA5);
    wait_data(4, 1'b0, "rst");
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_breq", 32'(breq), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_rdata", 32'(rdata), 32'd0);
    tick();
    got_n = 0;
    do_start(1'b1, 16'h00FF, 8'h5A);
    finish_txn("post", 1'b0, 8'h00);
    chk("post_bits", {8'h0, got[23:0]}, 32'h0000FF5A);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
